alu_writeback_stage: RTL and testbench

Write-back stage directly downstream of the MIPS ALU: captures each ALU result with its destination register number, commits it one cycle later into a 32 x 32-bit register file, and serves the two operand read ports (A, B) feeding the ALU, with bypass of the not-yet-committed result. It closes the loop that the read-only register file leaves open: it supplies RegWrite behaviour, a retired-instruction count and a sticky illegal-operation flag.

---
 rtl/alu_writeback_stage.sv | 103 ++++++++++
 tb/tb_alu_writeback_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Write-back stage behind the MIPS ALU: one-deep result register, 32x32 register
// file commit, bypassed A/B read ports, retired-write counter and sticky error flag.
module alu_writeback_stage #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             InValid,
    input  logic [31:0]      ALUOut,
    input  logic             Zero,
    input  logic [4:0]       WriteReg,
    input  logic [3:0]       ALUCtl,
    input  logic [4:0]       ReadReg1,
    input  logic [4:0]       ReadReg2,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             RegWrite,
    output logic             ZeroLast,
    output logic [CNT_W-1:0] Retired,
    output logic             Error
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [3:0]  ALUCTL_ILLEGAL = 4'd15;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          zero;
    } wb_entry_t;

    wb_entry_t     wb_q;
    logic [DW-1:0] regs_q [NREGS];
    logic          capture_c;
    logic          illegal_c;

    // Classify the incoming ALU result.
    always_comb begin
        capture_c = 1'b0;
        illegal_c = 1'b0;
        if (InValid) begin
            if (ALUCtl == ALUCTL_ILLEGAL) begin
                illegal_c = 1'b1;
            end else begin
                capture_c = 1'b1;
            end
        end
    end

    // WB stage register; payload only loads on a legal capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_q <= '0;
        end else begin
            wb_q.valid <= capture_c;
            if (capture_c) begin
                wb_q.addr <= WriteReg;
                wb_q.data <= ALUOut;
                wb_q.zero <= Zero;
            end
        end
    end

    // Commit into the array; a pending entry is dropped when reset hits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            Retired  <= '0;
            ZeroLast <= 1'b0;
        end else if (wb_q.valid) begin
            regs_q[wb_q.addr] <= wb_q.data;
            Retired           <= Retired + CNT_W'(1);
            ZeroLast          <= wb_q.zero;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Error <= 1'b0;
        end else if (illegal_c) begin
            Error <= 1'b1;
        end
    end

    // Read ports forward the uncommitted WB result when the address matches.
    always_comb begin
        A        = regs_q[ReadReg1];
        B        = regs_q[ReadReg2];
        RegWrite = wb_q.valid;
        if (wb_q.valid && (wb_q.addr == ReadReg1)) begin
            A = wb_q.data;
        end
        if (wb_q.valid && (wb_q.addr == ReadReg2)) begin
            B = wb_q.data;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: commits checked by a monitor on RegWrite,
// operand and flag values checked against hand-computed constants.
module tb_alu_writeback_stage;

    localparam int unsigned CNT_W = 4;

    logic             CLK;
    logic             RESET;
    logic             InValid;
    logic [31:0]      ALUOut;
    logic             Zero;
    logic [4:0]       WriteReg;
    logic [3:0]       ALUCtl;
    logic [4:0]       ReadReg1;
    logic [4:0]       ReadReg2;
    logic [31:0]      A;
    logic [31:0]      B;
    logic             RegWrite;
    logic             ZeroLast;
    logic [CNT_W-1:0] Retired;
    logic             Error;

    alu_writeback_stage #(.NREGS(32), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .InValid(InValid), .ALUOut(ALUOut), .Zero(Zero),
        .WriteReg(WriteReg), .ALUCtl(ALUCtl), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .A(A), .B(B), .RegWrite(RegWrite), .ZeroLast(ZeroLast), .Retired(Retired),
        .Error(Error)
    );

    typedef struct packed {
        logic [CNT_W-1:0] retired;
        logic             zero;
    } exp_t;

    exp_t             exp_q [$];
    exp_t             pend;
    bit               pend_v;
    logic [CNT_W-1:0] exp_retired;
    int               checks;
    int               errors;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: verify the previous commit, then pop the next one when RegWrite shows it.
    always @(negedge CLK) begin
        if (pend_v) begin
            check("commit_retired", 32'(Retired), 32'(pend.retired));
            check("commit_zerolast", 32'(ZeroLast), 32'(pend.zero));
            pend_v = 1'b0;
        end
        if (RegWrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_regwrite: got RegWrite=1 expected no commit at %0t", $time);
            end else begin
                pend = exp_q.pop_front();
                pend_v = !RESET;
            end
        end
    end

    // Present one result for the next edge, then step past it.
    task automatic issue(input logic [4:0] wr, input logic [31:0] d, input logic z,
                         input logic [3:0] ctl);
        InValid  = 1'b1;
        WriteReg = wr;
        ALUOut   = d;
        Zero     = z;
        ALUCtl   = ctl;
        if (ctl != 4'd15) begin
            exp_retired = exp_retired + CNT_W'(1);
            exp_q.push_back('{retired: exp_retired, zero: z});
        end
        @(posedge CLK);
        #1;
        InValid = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        pend_v      = 1'b0;
        exp_retired = '0;
        RESET       = 1'b1;
        InValid     = 1'b0;
        ALUOut      = '0;
        Zero        = 1'b0;
        WriteReg    = '0;
        ALUCtl      = '0;
        ReadReg1    = '0;
        ReadReg2    = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Reset state across every read address
        for (int r = 0; r < 32; r++) begin
            ReadReg1 = 5'(r);
            ReadReg2 = 5'(31 - r);
            #1;
            check("reset_a", A, 32'h0);
            check("reset_b", B, 32'h0);
        end
        check("reset_retired", 32'(Retired), 32'h0);
        check("reset_error", 32'(Error), 32'h0);
        check("reset_regwrite", 32'(RegWrite), 32'h0);
        check("reset_zerolast", 32'(ZeroLast), 32'h0);
        step();

        // Single write to reg 2
        ReadReg1 = 5'd2;
        issue(5'd2, 32'd7, 1'b0, 4'd2);
        check("single_bypass_a", A, 32'd7);
        check("single_regwrite", 32'(RegWrite), 32'h1);
        step();
        check("single_array_a", A, 32'd7);
        check("single_retired", 32'(Retired), 32'd1);
        check("single_regwrite_low", 32'(RegWrite), 32'h0);

        // Back-to-back writes to reg 11
        ReadReg1 = 5'd11;
        ReadReg2 = 5'd11;
        issue(5'd11, 32'd5, 1'b0, 4'd0);
        check("b2b_first_a", A, 32'd5);
        check("b2b_first_b", B, 32'd5);
        issue(5'd11, 32'd9, 1'b1, 4'd0);
        check("b2b_second_a", A, 32'd9);
        check("b2b_second_b", B, 32'd9);
        check("b2b_mid_retired", 32'(Retired), 32'd2);
        step();
        check("b2b_array_a", A, 32'd9);
        check("b2b_array_b", B, 32'd9);
        check("b2b_retired", 32'(Retired), 32'd3);

        // Write to reg 20 while reading 2 and 11: no bypass
        ReadReg1 = 5'd2;
        ReadReg2 = 5'd11;
        issue(5'd20, 32'hAA, 1'b0, 4'd2);
        check("nobypass_a", A, 32'd7);
        check("nobypass_b", B, 32'd9);
        step();

        // Illegal op, then a legal write
        ReadReg1 = 5'd3;
        issue(5'd3, 32'hFF, 1'b0, 4'd15);
        check("illegal_error", 32'(Error), 32'h1);
        check("illegal_a", A, 32'h0);
        check("illegal_regwrite", 32'(RegWrite), 32'h0);
        step();
        check("illegal_array_a", A, 32'h0);
        check("illegal_retired", 32'(Retired), 32'd4);
        issue(5'd5, 32'h55, 1'b0, 4'd0);
        step();
        check("illegal_sticky", 32'(Error), 32'h1);
        check("after_illegal_retired", 32'(Retired), 32'd5);

        // Reset while a capture is pending
        ReadReg1 = 5'd4;
        issue(5'd4, 32'h1234, 1'b0, 4'd2);
        check("midreset_bypass", A, 32'h1234);
        RESET = 1'b1;
        step();
        RESET       = 1'b0;
        exp_retired = '0;
        check("midreset_a", A, 32'h0);
        check("midreset_retired", 32'(Retired), 32'h0);
        check("midreset_regwrite", 32'(RegWrite), 32'h0);
        check("midreset_error", 32'(Error), 32'h0);
        ReadReg1 = 5'd2;
        #1;
        check("midreset_reg2", A, 32'h0);

        // Zero result, then counter wrap with a 4-bit counter
        ReadReg1 = 5'd14;
        issue(5'd14, 32'h0, 1'b1, 4'd3);
        step();
        check("zero_zerolast", 32'(ZeroLast), 32'h1);
        check("zero_retired", 32'(Retired), 32'd1);
        for (int i = 0; i < 16; i++) begin
            issue(5'(16 + (i % 8)), 32'(i + 100), 1'b0, 4'd2);
        end
        step();
        check("wrap_retired", 32'(Retired), 32'd1);
        check("wrap_zerolast", 32'(ZeroLast), 32'h0);
        ReadReg1 = 5'd23;
        ReadReg2 = 5'd14;
        #1;
        check("wrap_last_a", A, 32'd115);
        check("wrap_reg14_b", B, 32'h0);

        repeat (2) step();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        check("sb_no_pending", 32'(pend_v), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
